// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and default sizing constants used by
// both the PWM generator and the capture block.
package pwm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } pwm_state_e;

  localparam int unsigned DefCntW       = 16;
  localparam int unsigned DefSyncStages = 2;
  localparam int unsigned DefTimeout    = 1000;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizes the asynchronous PWM input and derives single-cycle rise/fall strobes
// from the synchronized level.
module pwm_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   din_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      din_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      din_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign din_s = sync_q[SYNC_STAGES-1];
  assign rise  = din_s & ~din_d_q;
  assign fall  = ~din_s & din_d_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time of a synchronized PWM input in clk
// cycles, publishes one result per completed cycle and flags lost/stuck signals.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned TIMEOUT     = DefTimeout
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] period_on,
  output logic             meas_valid,
  output logic             timeout,
  output logic             stuck_level,
  output logic             locked
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  // IDLE counts the pulse cycle itself so idle timeouts repeat every TIMEOUT cycles.
  localparam logic [CNT_W-1:0] IdleLimit  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] One        = CNT_W'(1);

  logic din_s, rise, fall;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .din_s(din_s),
    .rise (rise),
    .fall (fall)
  );

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_per_q, cnt_per_d;
  logic [CNT_W-1:0] cnt_on_q, cnt_on_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] period_on_q, period_on_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;
  logic             stuck_q, stuck_d;
  logic             locked_q, locked_d;
  logic             at_timeout;

  assign at_timeout = (cnt_per_q == TimeoutCnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_per_q    <= '0;
      cnt_on_q     <= '0;
      period_q     <= '0;
      period_on_q  <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      stuck_q      <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_per_q    <= cnt_per_d;
      cnt_on_q     <= cnt_on_d;
      period_q     <= period_d;
      period_on_q  <= period_on_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
      stuck_q      <= stuck_d;
      locked_q     <= locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (rise) state_d = StHigh;
        StHigh: begin
          if (at_timeout) state_d = StIdle;
          else if (fall)  state_d = StLow;
        end
        StLow: begin
          if (rise)            state_d = StHigh;
          else if (at_timeout) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_per_d    = cnt_per_q;
    cnt_on_d     = cnt_on_q;
    period_d     = period_q;
    period_on_d  = period_on_q;
    meas_valid_d = 1'b0;
    timeout_d    = 1'b0;
    stuck_d      = stuck_q;
    locked_d     = locked_q;
    if (!en) begin
      cnt_per_d = '0;
      cnt_on_d  = '0;
      locked_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            cnt_per_d = One;
            cnt_on_d  = One;
          end else if (cnt_per_q == IdleLimit) begin
            timeout_d = 1'b1;
            stuck_d   = din_s;
            cnt_per_d = '0;
          end else begin
            cnt_per_d = cnt_per_q + One;
          end
        end
        StHigh: begin
          if (at_timeout) begin
            timeout_d = 1'b1;
            stuck_d   = din_s;
            locked_d  = 1'b0;
            cnt_per_d = '0;
            cnt_on_d  = '0;
          end else if (fall) begin
            cnt_per_d = cnt_per_q + One;
          end else begin
            cnt_per_d = cnt_per_q + One;
            cnt_on_d  = cnt_on_q + One;
          end
        end
        StLow: begin
          // A rise exactly at the limit still completes the measurement.
          if (rise) begin
            period_d     = cnt_per_q;
            period_on_d  = cnt_on_q;
            meas_valid_d = 1'b1;
            locked_d     = 1'b1;
            cnt_per_d    = One;
            cnt_on_d     = One;
          end else if (at_timeout) begin
            timeout_d = 1'b1;
            stuck_d   = din_s;
            locked_d  = 1'b0;
            cnt_per_d = '0;
            cnt_on_d  = '0;
          end else begin
            cnt_per_d = cnt_per_q + One;
          end
        end
        default: begin
          cnt_per_d = '0;
          cnt_on_d  = '0;
        end
      endcase
    end
  end

  assign period      = period_q;
  assign period_on   = period_on_q;
  assign meas_valid  = meas_valid_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives PWM waveforms and checks measurements,
// lock behaviour, timeouts, reset and enable handling against hand-computed values.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic        din = 1'b0;
  logic [15:0] period, period_on;
  logic        meas_valid, timeout, stuck_level, locked;

  int cyc = 0;
  int mv_cnt = 0, mv_cyc = 0, mv_prev = 0;
  int to_cnt = 0, to_cyc = 0, to_prev = 0;
  int n_pass = 0, n_total = 0;

  pwm_capture u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .period     (period),
    .period_on  (period_on),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .stuck_level(stuck_level),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      mv_cnt  <= mv_cnt + 1;
      mv_prev <= mv_cyc;
      mv_cyc  <= cyc;
    end
    if (timeout === 1'b1) begin
      to_cnt  <= to_cnt + 1;
      to_prev <= to_cyc;
      to_cyc  <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic pwm_cycles(input int per, input int on, input int n);
    for (int k = 0; k < n; k++) begin
      din = 1'b1;
      repeat (on) @(negedge clk);
      din = 1'b0;
      repeat (per - on) @(negedge clk);
    end
  endtask

  task automatic wait_to(input int n0, input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (to_cnt != n0) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int m0, t0, c0;
    bit seen;

    // Reset
    repeat (4) @(negedge clk);
    check_eq("reset_outs", {period, period_on, meas_valid, timeout, stuck_level, locked}, '0);
    rst = 1'b0;

    // 1: steady 100/50
    pwm_cycles(100, 50, 4);
    check_eq("t1_mv_count", mv_cnt, 3);
    check_eq("t1_period", period, 100);
    check_eq("t1_period_on", period_on, 50);
    check_eq("t1_locked", locked, 1);
    check_eq("t1_mv_interval", mv_cyc - mv_prev, 100);

    // 2: duty extremes
    pwm_cycles(100, 1, 1);
    pwm_cycles(100, 99, 1);
    check_eq("t2_on1", period_on, 1);
    check_eq("t2_per_a", period, 100);
    pwm_cycles(100, 50, 1);
    check_eq("t2_on99", period_on, 99);
    check_eq("t2_per_b", period, 100);

    // 6: period change, then enable low
    pwm_cycles(60, 30, 1);
    check_eq("t6_old_per", period, 100);
    check_eq("t6_old_on", period_on, 50);
    pwm_cycles(60, 30, 1);
    check_eq("t6_new_per", period, 60);
    check_eq("t6_new_on", period_on, 30);
    check_eq("t6_mv_interval", mv_cyc - mv_prev, 60);
    m0 = mv_cnt;
    t0 = to_cnt;
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      din = 1'b1;
      repeat (3) @(negedge clk);
      din = 1'b0;
      repeat (2) @(negedge clk);
    end
    check_eq("t6_en_locked", locked, 0);
    check_eq("t6_en_no_pulse", {mv_cnt - m0, to_cnt - t0}, 0);
    check_eq("t6_en_hold", {period, period_on}, {16'd60, 16'd30});
    en = 1'b1;

    // 3: lock then stuck high
    pwm_cycles(100, 50, 2);
    din = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("t3_locked", locked, 1);
    t0 = to_cnt;
    wait_to(t0, 1200, seen);
    check_eq("t3_to_seen", seen, 1);
    check_eq("t3_to_delay", to_cyc - mv_cyc, 1000);
    check_eq("t3_stuck", stuck_level, 1);
    check_eq("t3_unlocked", locked, 0);
    check_eq("t3_per_hold", period, 100);
    t0 = to_cnt;
    wait_to(t0, 1200, seen);
    check_eq("t3_to2_seen", seen, 1);
    check_eq("t3_to_repeat", to_cyc - to_prev, 1000);

    // 4: din low from reset
    rst = 1'b1;
    din = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    c0 = cyc;
    t0 = to_cnt;
    wait_to(t0, 1200, seen);
    check_eq("t4_to_seen", seen, 1);
    check_eq("t4_to_delay", to_cyc - c0, 1000);
    t0 = to_cnt;
    wait_to(t0, 1200, seen);
    check_eq("t4_to_repeat", to_cyc - to_prev, 1000);
    check_eq("t4_stuck", stuck_level, 0);
    check_eq("t4_never_locked", locked, 0);

    // 5: one-cycle reset mid-HIGH
    pwm_cycles(100, 50, 2);
    din = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    din = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_rst_outs", {period, period_on, meas_valid, timeout, stuck_level, locked}, '0);
    m0 = mv_cnt;
    pwm_cycles(100, 50, 1);
    check_eq("t5_no_mv_first", mv_cnt - m0, 0);
    pwm_cycles(100, 50, 1);
    check_eq("t5_mv_second", mv_cnt - m0, 1);
    check_eq("t5_meas", {period, period_on}, {16'd100, 16'd50});

    // 7: rise exactly at the timeout count completes the measurement
    pwm_cycles(1000, 10, 1);
    t0 = to_cnt;
    pwm_cycles(1000, 10, 1);
    check_eq("t7_period", period, 1000);
    check_eq("t7_period_on", period_on, 10);
    check_eq("t7_no_timeout", to_cnt - t0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
